// File: rtl/crossbar_bus_pkg.sv
// crossbar_bus_pkg
//   Shared constants for the crossbar switch: default geometry and the
//   route-table entry encoding.
//   A route entry is {valid, sel[AW-1:0]}; valid sits at bit AW, sel below it.
//   The unsubscribe encoding is the all-zero entry {0, 0}.
package crossbar_bus_pkg;

  localparam int CB_AW = 3;  // signed width of 'from', unsigned width of 'to'
  localparam int CB_N  = 4;  // input lanes
  localparam int CB_M  = 4;  // output lanes
  localparam int CB_W  = 8;  // lane width

  // Valid bit carried by an unsubscribed entry (sel is forced to zero too).
  localparam logic CB_UNSUB_VALID = 1'b0;

endpackage

// File: rtl/crossbar_bus_if.sv
// crossbar_bus_if
//   Groups the crossbar data lanes, route-table write port and peek port.
//   master: the side that drives lanes and table writes (source / controller)
//   slave : the crossbar itself
//   Signals:
//     in[N*W]     input lanes, lane i = in[i*W +: W]
//     out[M*W]    registered output lanes
//     from        signed source index for put
//     to          destination output index for put
//     put/commit  table write / shadow->active copy, accepted every cycle
//     peek_to     output index to read back
//     peek_sel    registered active source of peek_to
//     peek_valid  registered subscription flag of peek_to
//     pending     uncommitted shadow writes exist
//   Handshake: there is none. put and commit are single-cycle strobes that are
//   always accepted on the edge where they are sampled high; no ready exists.
interface crossbar_bus_if
  import crossbar_bus_pkg::*;
#(
  parameter int AW = CB_AW,
  parameter int N  = CB_N,
  parameter int M  = CB_M,
  parameter int W  = CB_W
);

  logic [N*W-1:0]        in;
  logic [M*W-1:0]        out;
  logic signed [AW-1:0]  from;
  logic [AW-1:0]         to;
  logic                  put;
  logic                  commit;
  logic [AW-1:0]         peek_to;
  logic [AW-1:0]         peek_sel;
  logic                  peek_valid;
  logic                  pending;

  modport master (
    output in, from, to, put, commit, peek_to,
    input  out, peek_sel, peek_valid, pending
  );

  modport slave (
    input  in, from, to, put, commit, peek_to,
    output out, peek_sel, peek_valid, pending
  );

endinterface

// File: rtl/crossbar_bus_route_table.sv
// crossbar_route_table
//   Double-buffered routing table for the crossbar.
//   Writes (put) land in the shadow table; commit copies shadow to active,
//   including a put in the same cycle. With IMMEDIATE=1 a put also writes the
//   active table directly and pending never rises.
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-high reset
//     from, to, put       table write; to >= M is dropped entirely
//     commit              shadow -> active copy
//     peek_to             read-back index; peek_sel/peek_valid registered,
//                         reading the active table as it was before the edge
//     act_valid, act_sel  active table, flattened, for the data path
//     pending             accepted puts not yet committed
module crossbar_route_table
  import crossbar_bus_pkg::*;
#(
  parameter int AW        = CB_AW,
  parameter int N         = CB_N,
  parameter int M         = CB_M,
  parameter int IMMEDIATE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [AW-1:0] from,
  input  logic [AW-1:0]        to,
  input  logic                 put,
  input  logic                 commit,
  input  logic [AW-1:0]        peek_to,
  output logic [M-1:0]         act_valid,
  output logic [M*AW-1:0]      act_sel,
  output logic [AW-1:0]        peek_sel,
  output logic                 peek_valid,
  output logic                 pending
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] sel;
  } entry_t;

  entry_t shadow_q [M];
  entry_t active_q [M];
  entry_t shadow_d [M];
  entry_t active_d [M];
  entry_t wr_entry;
  entry_t peek_entry;
  logic   accept;
  logic   from_ok;

  // Compare in AW+1 bits so M = 2^AW and N = 2^(AW-1) fit without wrapping.
  always_comb begin
    accept  = put && ({1'b0, to} < (AW+1)'(M));
    // Negative sources (MSB set) and sources >= N unsubscribe the output.
    from_ok = !from[AW-1] && ({1'b0, from} < (AW+1)'(N));
    if (from_ok) begin
      wr_entry = '{valid: 1'b1, sel: from};
    end else begin
      wr_entry = '{valid: CB_UNSUB_VALID, sel: '0};
    end
  end

  // Next-state tables. The commit copy uses shadow_d, so a put in the same
  // cycle is forwarded into the committed table.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      shadow_d[j] = shadow_q[j];
      active_d[j] = active_q[j];
      if (accept && to == AW'(j)) begin
        shadow_d[j] = wr_entry;
        if (IMMEDIATE != 0) begin
          active_d[j] = wr_entry;
        end
      end
    end
    if (commit) begin
      for (int j = 0; j < M; j++) begin
        active_d[j] = shadow_d[j];
      end
    end
  end

  // Out-of-range peek_to matches no entry and reads back as {0, 0}.
  always_comb begin
    peek_entry = '0;
    for (int j = 0; j < M; j++) begin
      if (peek_to == AW'(j)) begin
        peek_entry = active_q[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < M; j++) begin
        shadow_q[j] <= '0;
        active_q[j] <= '0;
      end
      peek_sel   <= '0;
      peek_valid <= 1'b0;
      pending    <= 1'b0;
    end else begin
      for (int j = 0; j < M; j++) begin
        shadow_q[j] <= shadow_d[j];
        active_q[j] <= active_d[j];
      end
      peek_sel   <= peek_entry.sel;
      peek_valid <= peek_entry.valid;
      if (IMMEDIATE != 0 || commit) begin
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_flat
    assign act_valid[j]            = active_q[j].valid;
    assign act_sel[j*AW +: AW]     = active_q[j].sel;
  end

endmodule

// File: rtl/crossbar_bus.sv
// crossbar_bus
//   Registered N-input, M-output crossbar of W-bit lanes. Each output lane
//   registers the input lane selected by its active route entry, or IDLE when
//   the output is unsubscribed. Route changes take effect atomically on commit
//   (or immediately with IMMEDIATE=1), so outputs never see a partial table.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous active-high reset; outputs go to IDLE, tables clear
//     bus    crossbar_bus_if slave modport (lanes, put/commit, peek, pending)
module crossbar_bus
  import crossbar_bus_pkg::*;
#(
  parameter int           AW        = CB_AW,
  parameter int           N         = CB_N,
  parameter int           M         = CB_M,
  parameter int           W         = CB_W,
  parameter logic [W-1:0] IDLE      = '0,
  parameter int           IMMEDIATE = 0
) (
  input  logic          clock,
  input  logic          reset,
  crossbar_bus_if.slave bus
);

  logic [M-1:0]    act_valid;
  logic [M*AW-1:0] act_sel;
  logic [M*W-1:0]  out_d;
  logic [M*W-1:0]  out_q;

  crossbar_route_table #(
    .AW        (AW),
    .N         (N),
    .M         (M),
    .IMMEDIATE (IMMEDIATE)
  ) u_table (
    .clock      (clock),
    .reset      (reset),
    .from       (bus.from),
    .to         (bus.to),
    .put        (bus.put),
    .commit     (bus.commit),
    .peek_to    (bus.peek_to),
    .act_valid  (act_valid),
    .act_sel    (act_sel),
    .peek_sel   (bus.peek_sel),
    .peek_valid (bus.peek_valid),
    .pending    (bus.pending)
  );

  // The table only ever stores sel < N with valid=1, so the compare loop
  // always finds exactly one lane for a subscribed output.
  always_comb begin
    out_d = '0;
    for (int j = 0; j < M; j++) begin
      out_d[j*W +: W] = IDLE;
      if (act_valid[j]) begin
        for (int i = 0; i < N; i++) begin
          if (act_sel[j*AW +: AW] == AW'(i)) begin
            out_d[j*W +: W] = bus.in[i*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < M; j++) begin
        out_q[j*W +: W] <= IDLE;
      end
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule
